// File: rtl/st7789_spi_sink_pkg.sv
// Shared definitions for the ST7789 serial-link receiver: command codes,
// decoder states and default panel geometry.
package st7789_spi_sink_pkg;

    localparam logic [7:0] CMD_SWRESET = 8'h01;
    localparam logic [7:0] CMD_CASET   = 8'h2A;
    localparam logic [7:0] CMD_RASET   = 8'h2B;
    localparam logic [7:0] CMD_RAMWR   = 8'h2C;

    localparam int DEF_WIDTH        = 240;
    localparam int DEF_HEIGHT       = 240;
    localparam int DEF_IDLE_TIMEOUT = 64;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR
    } dec_state_e;

endpackage

// File: rtl/st7789_spi_sink_spi_byte_rx.sv
// Oversampling receiver for the 3-wire SCL/SDA/DC link: rebuilds bytes from
// SCL rising edges and drops a partial byte when the clock stalls.
module spi_byte_rx
    import st7789_spi_sink_pkg::*;
#(
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    input  logic       dc_i,
    output logic       byte_valid_o,
    output logic       dc_o,
    output logic [7:0] byte_o,
    output logic       sync_err_o
);
    localparam int            IW        = $clog2(IDLE_TIMEOUT + 1);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_TIMEOUT - 1);

    logic          scl_s_q, scl_p_q, sda_s_q, sda_p_q, dc_s_q;
    logic          rise_q, bit_q, bdc_q;
    logic [2:0]    cnt_q, cnt_d;
    logic [6:0]    shift_q, shift_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          valid_q, valid_d;
    logic          dc_q, dc_d;
    logic [7:0]    byte_q, byte_d;
    logic          serr_q, serr_d;

    // The sender moves SDA on the edge that raises SCL, so the bit is the
    // SDA sample taken one cycle before the rising edge was seen.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        idle_d  = idle_q;
        valid_d = 1'b0;
        dc_d    = dc_q;
        byte_d  = byte_q;
        serr_d  = 1'b0;
        if (rise_q) begin
            idle_d  = '0;
            shift_d = {shift_q[5:0], bit_q};
            cnt_d   = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
                valid_d = 1'b1;
                byte_d  = {shift_q, bit_q};
                dc_d    = bdc_q;
            end
        end else if (cnt_q != 3'd0) begin
            if (idle_q == IDLE_LAST) begin
                cnt_d  = 3'd0;
                idle_d = '0;
                serr_d = 1'b1;
            end else begin
                idle_d = idle_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_s_q <= 1'b1;
            scl_p_q <= 1'b1;
            sda_s_q <= 1'b0;
            sda_p_q <= 1'b0;
            dc_s_q  <= 1'b0;
            rise_q  <= 1'b0;
            bit_q   <= 1'b0;
            bdc_q   <= 1'b0;
            cnt_q   <= 3'd0;
            shift_q <= 7'd0;
            idle_q  <= '0;
            valid_q <= 1'b0;
            dc_q    <= 1'b0;
            byte_q  <= 8'd0;
            serr_q  <= 1'b0;
        end else begin
            scl_s_q <= scl_i;
            scl_p_q <= scl_s_q;
            sda_s_q <= sda_i;
            sda_p_q <= sda_s_q;
            dc_s_q  <= dc_i;
            rise_q  <= scl_s_q & ~scl_p_q;
            bit_q   <= sda_p_q;
            bdc_q   <= dc_s_q;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idle_q  <= idle_d;
            valid_q <= valid_d;
            dc_q    <= dc_d;
            byte_q  <= byte_d;
            serr_q  <= serr_d;
        end
    end

    assign byte_valid_o = valid_q;
    assign dc_o         = dc_q;
    assign byte_o       = byte_q;
    assign sync_err_o   = serr_q;

endmodule

// File: rtl/st7789_spi_sink.sv
// ST7789 command/pixel decoder: turns received {DC, byte} words into window
// updates and writes into a 256x256 video-memory port.
module st7789_spi_sink
    import st7789_spi_sink_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int HEIGHT       = DEF_HEIGHT,
    parameter int IDLE_TIMEOUT = DEF_IDLE_TIMEOUT
) (
    input  logic        w_clk,
    input  logic        w_rst,
    input  logic        SCL,
    input  logic        SDA,
    input  logic        DC,
    output logic        o_we,
    output logic [15:0] o_waddr,
    output logic [15:0] o_wdata,
    output logic        o_cmd_valid,
    output logic [7:0]  o_cmd,
    output logic        o_frame_done,
    output logic        o_sync_err
);
    localparam logic [16:0] X_LIM  = 17'(WIDTH);
    localparam logic [16:0] Y_LIM  = 17'(HEIGHT);
    localparam logic [15:0] XE_RST = 16'(WIDTH - 1);
    localparam logic [15:0] YE_RST = 16'(HEIGHT - 1);

    logic       rx_valid, rx_dc;
    logic [7:0] rx_byte;

    spi_byte_rx #(
        .IDLE_TIMEOUT(IDLE_TIMEOUT)
    ) u_rx (
        .clk_i       (w_clk),
        .rst_i       (w_rst),
        .scl_i       (SCL),
        .sda_i       (SDA),
        .dc_i        (DC),
        .byte_valid_o(rx_valid),
        .dc_o        (rx_dc),
        .byte_o      (rx_byte),
        .sync_err_o  (o_sync_err)
    );

    dec_state_e  state_q, state_d;
    logic [1:0]  arg_idx_q, arg_idx_d;
    logic [23:0] arg_q, arg_d;
    logic        phase_q, phase_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [15:0] x_q, x_d, y_q, y_d;
    logic        we_q, we_d, cmd_valid_q, cmd_valid_d, fd_q, fd_d;
    logic [15:0] waddr_q, waddr_d, wdata_q, wdata_d;
    logic [7:0]  cmd_q, cmd_d;
    logic        x_last, y_last, in_view;

    assign x_last  = (x_q == xe_q);
    assign y_last  = (y_q == ye_q);
    assign in_view = ({1'b0, x_q} < X_LIM) && ({1'b0, y_q} < Y_LIM);

    always_comb begin
        state_d     = state_q;
        arg_idx_d   = arg_idx_q;
        arg_d       = arg_q;
        phase_d     = phase_q;
        hi_d        = hi_q;
        xs_d        = xs_q;
        xe_d        = xe_q;
        ys_d        = ys_q;
        ye_d        = ye_q;
        x_d         = x_q;
        y_d         = y_q;
        we_d        = 1'b0;
        cmd_valid_d = 1'b0;
        fd_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        cmd_d       = cmd_q;
        if (rx_valid && !rx_dc) begin
            // A command always resynchronises the decoder, whatever it was doing.
            cmd_valid_d = 1'b1;
            cmd_d       = rx_byte;
            phase_d     = 1'b0;
            arg_idx_d   = 2'd0;
            case (rx_byte)
                CMD_CASET: state_d = ST_CASET;
                CMD_RASET: state_d = ST_RASET;
                CMD_RAMWR: begin
                    state_d = ST_RAMWR;
                    x_d     = xs_q;
                    y_d     = ys_q;
                end
                CMD_SWRESET: begin
                    state_d = ST_IDLE;
                    xs_d    = 16'd0;
                    xe_d    = XE_RST;
                    ys_d    = 16'd0;
                    ye_d    = YE_RST;
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (rx_valid) begin
            case (state_q)
                ST_CASET, ST_RASET: begin
                    arg_idx_d = arg_idx_q + 2'd1;
                    case (arg_idx_q)
                        2'd0: arg_d[23:16] = rx_byte;
                        2'd1: arg_d[15:8]  = rx_byte;
                        2'd2: arg_d[7:0]   = rx_byte;
                        default: begin
                            state_d = ST_IDLE;
                            if (state_q == ST_CASET) begin
                                xs_d = arg_q[23:8];
                                xe_d = {arg_q[7:0], rx_byte};
                            end else begin
                                ys_d = arg_q[23:8];
                                ye_d = {arg_q[7:0], rx_byte};
                            end
                        end
                    endcase
                end
                ST_RAMWR: begin
                    if (!phase_q) begin
                        hi_d    = rx_byte;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        we_d    = in_view;
                        fd_d    = x_last && y_last;
                        waddr_d = {y_q[7:0], x_q[7:0]};
                        wdata_d = {hi_q, rx_byte};
                        if (x_last) begin
                            x_d = xs_q;
                            y_d = y_last ? ys_q : y_q + 16'd1;
                        end else begin
                            x_d = x_q + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge w_clk) begin
        if (w_rst) begin
            state_q     <= ST_IDLE;
            arg_idx_q   <= 2'd0;
            arg_q       <= 24'd0;
            phase_q     <= 1'b0;
            hi_q        <= 8'd0;
            xs_q        <= 16'd0;
            xe_q        <= XE_RST;
            ys_q        <= 16'd0;
            ye_q        <= YE_RST;
            x_q         <= 16'd0;
            y_q         <= 16'd0;
            we_q        <= 1'b0;
            cmd_valid_q <= 1'b0;
            fd_q        <= 1'b0;
            waddr_q     <= 16'd0;
            wdata_q     <= 16'd0;
            cmd_q       <= 8'd0;
        end else begin
            state_q     <= state_d;
            arg_idx_q   <= arg_idx_d;
            arg_q       <= arg_d;
            phase_q     <= phase_d;
            hi_q        <= hi_d;
            xs_q        <= xs_d;
            xe_q        <= xe_d;
            ys_q        <= ys_d;
            ye_q        <= ye_d;
            x_q         <= x_d;
            y_q         <= y_d;
            we_q        <= we_d;
            cmd_valid_q <= cmd_valid_d;
            fd_q        <= fd_d;
            waddr_q     <= waddr_d;
            wdata_q     <= wdata_d;
            cmd_q       <= cmd_d;
        end
    end

    assign o_we         = we_q;
    assign o_waddr      = waddr_q;
    assign o_wdata      = wdata_q;
    assign o_cmd_valid  = cmd_valid_q;
    assign o_cmd        = cmd_q;
    assign o_frame_done = fd_q;

endmodule

// File: tb/tb_st7789_spi_sink.sv
// Randomised bench for st7789_spi_sink: drives the serial link bit by bit and
// compares decoded writes/commands against a queue-based model of the panel.
module tb_st7789_spi_sink;
    localparam int W  = 16;
    localparam int H  = 16;
    localparam int TO = 64;

    logic        w_clk = 1'b0;
    logic        w_rst, SCL, SDA, DC;
    logic        o_we, o_cmd_valid, o_frame_done, o_sync_err;
    logic [15:0] o_waddr, o_wdata;
    logic [7:0]  o_cmd;

    st7789_spi_sink #(.WIDTH(W), .HEIGHT(H), .IDLE_TIMEOUT(TO)) dut (
        .w_clk(w_clk), .w_rst(w_rst), .SCL(SCL), .SDA(SDA), .DC(DC),
        .o_we(o_we), .o_waddr(o_waddr), .o_wdata(o_wdata),
        .o_cmd_valid(o_cmd_valid), .o_cmd(o_cmd),
        .o_frame_done(o_frame_done), .o_sync_err(o_sync_err)
    );

    // clock / reset
    always #5 w_clk = ~w_clk;
    int cyc = 0;
    always @(posedge w_clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int checks = 0, failures = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // reference model: window registers, write position, byte queues
    logic [15:0] mxs, mxe, mys, mye, mx, my;
    int          m_mode;  // 0 ignore, 1 column args, 2 row args, 3 pixels
    logic [7:0]  m_args[$];
    logic [7:0]  m_pix[$];
    logic [33:0] exp_q[$];  // {we, frame_done, addr, data}
    logic [7:0]  cmd_exp[$];

    task automatic model_reset();
        mxs = 16'd0; mxe = 16'(W - 1); mys = 16'd0; mye = 16'(H - 1);
        mx = 16'd0; my = 16'd0; m_mode = 0;
        m_args.delete(); m_pix.delete();
    endtask

    task automatic model_byte(input logic d, input logic [7:0] b);
        logic we, fd;
        if (!d) begin
            cmd_exp.push_back(b);
            m_pix.delete();
            m_args.delete();
            case (b)
                8'h2A: m_mode = 1;
                8'h2B: m_mode = 2;
                8'h2C: begin m_mode = 3; mx = mxs; my = mys; end
                8'h01: begin
                    mxs = 16'd0; mxe = 16'(W - 1); mys = 16'd0; mye = 16'(H - 1);
                    m_mode = 0;
                end
                default: m_mode = 0;
            endcase
        end else if (m_mode == 1 || m_mode == 2) begin
            m_args.push_back(b);
            if (m_args.size() == 4) begin
                if (m_mode == 1) begin
                    mxs = {m_args[0], m_args[1]}; mxe = {m_args[2], m_args[3]};
                end else begin
                    mys = {m_args[0], m_args[1]}; mye = {m_args[2], m_args[3]};
                end
                m_args.delete();
                m_mode = 0;
            end
        end else if (m_mode == 3) begin
            m_pix.push_back(b);
            if (m_pix.size() == 2) begin
                we = (32'(mx) < W) && (32'(my) < H);
                fd = (mx == mxe) && (my == mye);
                if (we || fd) exp_q.push_back({we, fd, my[7:0], mx[7:0], m_pix[0], m_pix[1]});
                if (mx == mxe) begin
                    mx = mxs;
                    my = (my == mye) ? mys : my + 16'd1;
                end else begin
                    mx = mx + 16'd1;
                end
                m_pix.delete();
            end
        end
    endtask

    // driver tasks
    int last_byte_rise = 0, last_any_rise = 0;

    task automatic send_bits(input logic d, input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            SCL = 1'b0; SDA = b[i]; DC = d;
            repeat ($urandom_range(1, 2)) @(negedge w_clk);
            SCL = 1'b1;
            SDA = 1'($urandom_range(0, 1));  // sender shifts on the raising edge
            last_any_rise = cyc + 1;
            if (i == 0) begin
                last_byte_rise = cyc + 1;
                model_byte(d, b);
            end
            repeat ($urandom_range(1, 2)) @(negedge w_clk);
        end
    endtask

    task automatic cmd(input logic [7:0] b);
        send_bits(1'b0, b, 8);
    endtask

    task automatic dat(input logic [7:0] b);
        send_bits(1'b1, b, 8);
    endtask

    task automatic pixels(input int n);
        for (int i = 0; i < n; i++) begin
            dat(8'($urandom));
            dat(8'($urandom));
        end
    endtask

    task automatic window(input logic [15:0] xs, xe, ys, ye);
        cmd(8'h2A); dat(xs[15:8]); dat(xs[7:0]); dat(xe[15:8]); dat(xe[7:0]);
        cmd(8'h2B); dat(ys[15:8]); dat(ys[7:0]); dat(ye[15:8]); dat(ye[7:0]);
    endtask

    task automatic drain();
        int k = 0;
        while ((exp_q.size() != 0 || cmd_exp.size() != 0) && k < 100) begin
            @(negedge w_clk);
            k++;
        end
        check("drain_pix", 64'(exp_q.size()), 0);
        check("drain_cmd", 64'(cmd_exp.size()), 0);
        repeat (4) @(negedge w_clk);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_we"}, 64'(o_we), 0);
        check({tag, "_waddr"}, 64'(o_waddr), 0);
        check({tag, "_wdata"}, 64'(o_wdata), 0);
        check({tag, "_cmd_valid"}, 64'(o_cmd_valid), 0);
        check({tag, "_cmd"}, 64'(o_cmd), 0);
        check({tag, "_frame_done"}, 64'(o_frame_done), 0);
        check({tag, "_sync_err"}, 64'(o_sync_err), 0);
    endtask

    // scoreboard
    int we_cnt = 0, fd_cnt = 0, serr_cnt = 0, exp_serr = 0;

    always @(negedge w_clk) begin
        if (w_rst !== 1'b1) begin
            if (o_we || o_frame_done) begin
                we_cnt += int'(o_we);
                fd_cnt += int'(o_frame_done);
                if (exp_q.size() == 0) begin
                    check("pix_unexpected", 64'({o_we, o_frame_done}), 0);
                end else begin
                    logic [33:0] e;
                    e = exp_q.pop_front();
                    check("pix_we", 64'(o_we), 64'(e[33]));
                    check("pix_frame_done", 64'(o_frame_done), 64'(e[32]));
                    if (e[33]) begin
                        check("pix_addr", 64'(o_waddr), 64'(e[31:16]));
                        check("pix_data", 64'(o_wdata), 64'(e[15:0]));
                    end
                    check("pix_latency", 64'(cyc - last_byte_rise), 3);
                end
            end
            if (o_cmd_valid) begin
                if (cmd_exp.size() == 0) begin
                    check("cmd_unexpected", 64'(o_cmd_valid), 0);
                end else begin
                    check("cmd_value", 64'(o_cmd), 64'(cmd_exp.pop_front()));
                    check("cmd_latency", 64'(cyc - last_byte_rise), 3);
                end
            end
            if (o_sync_err) begin
                serr_cnt++;
                check("sync_err_delay", 64'((cyc - last_any_rise) >= TO), 1);
            end
        end
    end

    // stimulus
    initial begin
        int we0, fd0, serr0, k;
        SCL = 1'b1; SDA = 1'b0; DC = 1'b0; w_rst = 1'b1;
        model_reset();
        repeat (3) @(negedge w_clk);
        check_zero_outputs("reset");
        w_rst = 1'b0;
        repeat (2) @(negedge w_clk);

        // default window: two pixels land at 0x0000 and 0x0001
        cmd(8'h2C);
        dat(8'hF8); dat(8'h00);
        dat(8'h07); dat(8'hE0);
        drain();

        // small window, frame_done on the last pixel
        we0 = we_cnt; fd0 = fd_cnt;
        window(16'd10, 16'd12, 16'd5, 16'd5);
        cmd(8'h2C);
        pixels(3);
        drain();
        check("win_we_count", 64'(we_cnt - we0), 3);
        check("win_fd_count", 64'(fd_cnt - fd0), 1);

        // SWRESET after a half pixel: nothing written, window restored
        we0 = we_cnt;
        cmd(8'h2C);
        dat(8'hAB);
        cmd(8'h01);
        drain();
        check("swreset_cmd", 64'(o_cmd), 64'h01);
        check("swreset_no_we", 64'(we_cnt - we0), 0);
        cmd(8'h2C);
        pixels(2);
        drain();

        // window one past the visible area: edge column/row suppressed
        we0 = we_cnt; fd0 = fd_cnt;
        window(16'd0, 16'(W), 16'd0, 16'(H));
        cmd(8'h2C);
        pixels((W + 1) * (H + 1));
        drain();
        check("full_we_count", 64'(we_cnt - we0), 64'(W * H));
        check("full_fd_count", 64'(fd_cnt - fd0), 1);

        // stalled partial byte is dropped, then reception resumes
        we0 = we_cnt; serr0 = serr_cnt;
        send_bits(1'b1, 8'($urandom), 3);
        k = 0;
        while (serr_cnt == serr0 && k < TO + 40) begin
            @(negedge w_clk);
            k++;
        end
        exp_serr++;
        repeat (4) @(negedge w_clk);
        check("timeout_sync_err", 64'(serr_cnt - serr0), 1);
        check("timeout_no_we", 64'(we_cnt - we0), 0);
        cmd(8'h2C);
        pixels(2);
        drain();

        // column window that wraps through 0xFFFF
        window(16'hFFFE, 16'h0001, 16'd3, 16'd3);
        cmd(8'h2C);
        pixels(6);
        drain();

        // random windows, ignored commands and interrupted pixels
        for (int t = 0; t < 4; t++) begin
            logic [15:0] xs, ys;
            xs = 16'($urandom_range(0, 20));
            ys = 16'($urandom_range(0, 20));
            window(xs, xs + 16'($urandom_range(0, 4)), ys, ys + 16'($urandom_range(0, 3)));
            cmd(8'h36);
            dat(8'($urandom));
            cmd(8'h2C);
            pixels($urandom_range(1, 25));
            if ($urandom_range(0, 1) == 1) begin
                dat(8'($urandom));
                cmd(8'h00);
                dat(8'($urandom));
            end
            drain();
        end

        // reset in the middle of a pixel
        cmd(8'h2C);
        pixels(1);
        dat(8'h5A);
        drain();
        send_bits(1'b1, 8'hC3, 3);
        SCL = 1'b1;
        w_rst = 1'b1;
        @(negedge w_clk);
        check_zero_outputs("midreset");
        w_rst = 1'b0;
        model_reset();
        repeat (2) @(negedge w_clk);
        we0 = we_cnt;
        cmd(8'h2C);
        pixels(2);
        drain();
        check("restart_we_count", 64'(we_cnt - we0), 2);

        check("sync_err_total", 64'(serr_cnt), 64'(exp_serr));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
